apb_slave_mem: RTL and testbench

//  APB completer sitting directly downstream of the APB bridge. It consumes the bridge's

---
 rtl/apb_slave_mem.sv | 183 ++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with a word-addressed register memory.
//   Byte-strobed writes, programmable wait states, and an error response for
//   out-of-range, misaligned, or unprivileged-write accesses.
// Ports:
//   pclk, presetn        clock, async active-low reset
//   psel, penable        APB select / access-phase strobe
//   pwrite, paddr        direction and byte address
//   pwdata, pstrb        write data and byte-lane enables
//   pprot                protection; pprot[0] = privileged
//   prdata               read data, loaded when a read's pready rises
//   pready, pslverr      one-cycle completion pulse and its error flag
module apb_slave_mem #(
    parameter int unsigned D_WIDTH     = 32,
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [D_WIDTH-1:0] paddr,
    input  logic [D_WIDTH-1:0] pwdata,
    input  logic [3:0]         pstrb,
    input  logic [2:0]         pprot,
    output logic [D_WIDTH-1:0] prdata,
    output logic               pready,
    output logic               pslverr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SPAN  = DEPTH * 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic [D_WIDTH-1:0]   prdata_q, prdata_d;
    logic                 take_setup;

    // Transfer attributes captured at setup
    logic [IDX_W-1:0]     idx_q;
    logic                 write_q;
    logic                 err_q;
    logic [D_WIDTH-1:0]   wdata_q;
    logic [3:0]           strb_q;

    logic [D_WIDTH-1:0]   mem [DEPTH];

    // Setup-phase decode of the live bus
    logic [D_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]     setup_idx;
    logic                 setup_err;
    logic [D_WIDTH-1:0]   merged;
    logic                 commit;
    logic [D_WIDTH-1:0]   setup_rd_word;
    logic                 prot_unused;

    assign prot_unused = ^pprot[2:1];

    // Unsigned wrap makes addresses below BASE_ADDR land out of range too
    assign offset    = paddr - BASE_ADDR;
    assign setup_idx = offset[IDX_W+1:2];
    assign setup_err = (offset >= D_WIDTH'(SPAN)) || (paddr[1:0] != 2'b00)
                     || (pwrite && !pprot[0]);

    // Byte-lane merge of the captured write into the addressed word
    always_comb begin
        merged = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    assign commit = (state_q == ACCESS) && pready_q && write_q && !err_q;

    // Forward a write committing this edge to a zero-wait read set up on the same edge
    assign setup_rd_word = (commit && (idx_q == setup_idx)) ? merged : mem[setup_idx];

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = prdata_q;
        take_setup = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) take_setup = 1'b1;
            end
            ACCESS: begin
                if (pready_q) begin
                    // Completion edge
                    cnt_d = '0;
                    if (psel && !penable) take_setup = 1'b1;
                    else                  state_d    = IDLE;
                end else if (psel && penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q;
                            if (!write_q) prdata_d = err_q ? '0 : mem[idx_q];
                        end
                    end
                end else begin
                    // Abort before completion
                    cnt_d = '0;
                    if (psel && !penable) take_setup = 1'b1;
                    else                  state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_setup) begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
                pready_d  = 1'b1;
                pslverr_d = setup_err;
                if (!pwrite) prdata_d = setup_err ? '0 : setup_rd_word;
            end
        end
    end

    // Setup capture
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (take_setup) begin
            idx_q   <= setup_idx;
            write_q <= pwrite;
            err_q   <= setup_err;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    // Memory array, written only on a successful completion edge
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (commit) begin
            mem[idx_q] <= merged;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with 2 wait states, one with 0.
module tb_apb_slave_mem;

    logic        pclk;
    logic        presetn;
    logic        psel_w2, psel_w0;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata_w2, prdata_w0;
    logic        pready_w2, pready_w0;
    logic        pslverr_w2, pslverr_w0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    apb_slave_mem #(.D_WIDTH(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut_w2 (
        .pclk(pclk), .presetn(presetn), .psel(psel_w2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_w2), .pready(pready_w2), .pslverr(pslverr_w2)
    );

    apb_slave_mem #(.D_WIDTH(32), .DEPTH(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_w0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_w0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_w0), .pready(pready_w0), .pslverr(pslverr_w0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full APB transfer, entered and left #1 after a rising edge.
    // Bus fields are scrambled during the access phase to prove they were captured at setup.
    task automatic apb_xfer(input bit w0, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, output logic [31:0] rdata,
                            output logic err, output int cycles);
        psel_w2 = !w0; psel_w0 = w0; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = ~addr; pwdata = ~data; pstrb = ~strb;
        cycles = 1;
        while (!(w0 ? pready_w0 : pready_w2) && cycles < 32) begin
            @(posedge pclk); #1;
            cycles++;
        end
        rdata = w0 ? prdata_w0 : prdata_w2;
        err   = w0 ? pslverr_w0 : pslverr_w2;
        @(posedge pclk); #1;
        psel_w2 = 1'b0; psel_w0 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        psel_w2 = 1'b0; psel_w0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        #12;
        vectors++; if (pready_w2 !== 1'b0) begin miscompares++; $display("FAIL rst_pready_w2: got %b want 0", pready_w2); end
        vectors++; if (pslverr_w2 !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr_w2: got %b want 0", pslverr_w2); end
        vectors++; if (prdata_w2 !== 32'h0) begin miscompares++; $display("FAIL rst_prdata_w2: got %h want 0", prdata_w2); end
        vectors++; if (pready_w0 !== 1'b0) begin miscompares++; $display("FAIL rst_pready_w0: got %b want 0", pready_w0); end
        vectors++; if (prdata_w0 !== 32'h0) begin miscompares++; $display("FAIL rst_prdata_w0: got %h want 0", prdata_w0); end
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_wait2_write_read();
        logic [31:0] rd; logic er; int cy;
        apb_xfer(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cy);
        vectors++; if (cy !== 3) begin miscompares++; $display("FAIL w2_wr_latency: got %0d want 3", cy); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL w2_wr_err: got %b want 0", er); end
        apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (cy !== 3) begin miscompares++; $display("FAIL w2_rd_latency: got %0d want 3", cy); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL w2_rd_data: got %h want deadbeef", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL w2_rd_err: got %b want 0", er); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er; int cy;
        apb_xfer(1'b0, 1'b1, 32'h4, 32'h11223344, 4'b0101, 3'b001, rd, er, cy);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL strb_wr_err: got %b want 0", er); end
        apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL strb_rd_data: got %h want de22be44", rd); end
        // Zero strobes: legal, no change
        apb_xfer(1'b0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL strb0_err: got %b want 0", er); end
        apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL strb0_rd_data: got %h want de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cy;
        apb_xfer(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL err_range_flag: got %b want 1", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL err_range_rdata: got %h want 0", rd); end
        vectors++; if (cy !== 3) begin miscompares++; $display("FAIL err_range_latency: got %0d want 3", cy); end
        apb_xfer(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, cy);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL err_align_flag: got %b want 1", er); end
        // Unprivileged read is legal and word 1 must be untouched
        apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, cy);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL unpriv_rd_err: got %b want 0", er); end
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL err_align_mem: got %h want de22be44", rd); end
        apb_xfer(1'b0, 1'b1, 32'h8, 32'h5555AAAA, 4'hF, 3'b000, rd, er, cy);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL err_unpriv_flag: got %b want 1", er); end
        apb_xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL err_unpriv_mem: got %h want 0", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL err_unpriv_rd_err: got %b want 0", er); end
        // Last legal word
        apb_xfer(1'b0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, cy);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL top_wr_err: got %b want 0", er); end
        apb_xfer(1'b0, 1'b0, 32'hFC, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL top_rd_data: got %h want cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cy_w, cy_r, c0, c1;
        c0 = cyc;
        apb_xfer(1'b1, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 3'b001, rd, er, cy_w);
        apb_xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er, cy_r);
        c1 = cyc;
        vectors++; if (cy_w !== 1) begin miscompares++; $display("FAIL b2b_wr_latency: got %0d want 1", cy_w); end
        vectors++; if (cy_r !== 1) begin miscompares++; $display("FAIL b2b_rd_latency: got %0d want 1", cy_r); end
        vectors++; if (c1 - c0 !== 4) begin miscompares++; $display("FAIL b2b_total_cycles: got %0d want 4", c1 - c0); end
        vectors++; if (rd !== 32'h0BADCAFE) begin miscompares++; $display("FAIL b2b_rd_data: got %h want 0badcafe", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL b2b_rd_err: got %b want 0", er); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int cy; logic seen;
        psel_w2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel_w2 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | pready_w2;
            @(posedge pclk); #1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_pready: got %b want 0", seen); end
        apb_xfer(1'b0, 1'b0, 32'hC, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL abort_mem: got %h want 0", rd); end
        vectors++; if (cy !== 3) begin miscompares++; $display("FAIL abort_next_latency: got %0d want 3", cy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int cy; int n;
        logic [31:0] addrs [6];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'hFC};
        apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'hDE22BE44) begin miscompares++; $display("FAIL rmid_pre_rd: got %h want de22be44", rd); end
        psel_w2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        while (!pready_w2 && n < 32) begin
            @(posedge pclk); #1;
            n++;
        end
        vectors++; if (pready_w2 !== 1'b1) begin miscompares++; $display("FAIL rmid_pready_before: got %b want 1", pready_w2); end
        #2 presetn = 1'b0;
        #1;
        vectors++; if (pready_w2 !== 1'b0) begin miscompares++; $display("FAIL rmid_pready: got %b want 0", pready_w2); end
        vectors++; if (pslverr_w2 !== 1'b0) begin miscompares++; $display("FAIL rmid_pslverr: got %b want 0", pslverr_w2); end
        vectors++; if (prdata_w2 !== 32'h0) begin miscompares++; $display("FAIL rmid_prdata: got %h want 0", prdata_w2); end
        psel_w2 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        foreach (addrs[i]) begin
            apb_xfer(1'b0, 1'b0, addrs[i], 32'h0, 4'h0, 3'b001, rd, er, cy);
            vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rmid_clear_%h: got %h want 0", addrs[i], rd); end
        end
        apb_xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er, cy);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rmid_clear_w0: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_wait2_write_read();
        test_strobes();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
